// File: rtl/mem_arbiter.sv
// mem_arbiter: N-master arbiter in front of a single-port RAM with a fixed
// one-cycle read latency. Arbitration is combinational; every grant gets
// exactly one response pulse on the following cycle, carrying read data for
// in-range reads and an error flag for accesses outside the RAM window.
//
// Handshake: a master raises req_i with we/be/addr/wdata stable and holds all
// of them until it sees gnt_o high in the same cycle; that cycle is the
// transfer. The response (rvalid_o/err_o/rdata_o) is valid for exactly the
// next cycle, with no back-pressure on either side.
module mem_arbiter #(
  parameter int          NumMasters = 2,
  parameter int          AddrWidth  = 32,
  parameter int          DataWidth  = 32,
  parameter logic [31:0] MemStart   = 32'h00000000,
  parameter int unsigned MemSize    = 8192,
  parameter int          RoundRobin = 1,
  localparam int         BeWidth    = DataWidth / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumMasters-1:0]           req_i,
  input  logic [NumMasters-1:0]           we_i,
  input  logic [NumMasters*BeWidth-1:0]   be_i,
  input  logic [NumMasters*AddrWidth-1:0] addr_i,
  input  logic [NumMasters*DataWidth-1:0] wdata_i,
  output logic [NumMasters-1:0]           gnt_o,
  output logic [NumMasters-1:0]           rvalid_o,
  output logic [NumMasters-1:0]           err_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [BeWidth-1:0]              mem_be_o,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  input  logic [DataWidth-1:0]            mem_rdata_i
);

  localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
  localparam logic [AddrWidth-1:0] AddrMask = ~(AddrWidth'(MemSize - 1));
  localparam logic [AddrWidth-1:0] AddrBase = AddrWidth'(MemStart);
  localparam logic [IdxW-1:0]      PtrInit  = IdxW'(NumMasters - 1);

  // last-granted pointer and the one-deep response register
  logic [IdxW-1:0]      r_ptr;
  logic                 r_rsp_valid;
  logic [IdxW-1:0]      r_rsp_idx;
  logic                 r_rsp_err;
  logic                 r_rsp_rd;

  logic                 w_any;
  logic [IdxW-1:0]      w_idx;
  logic                 w_we;
  logic [BeWidth-1:0]   w_be;
  logic [AddrWidth-1:0] w_addr;
  logic [DataWidth-1:0] w_wdata;
  logic                 w_inrange;
  logic                 w_access;

  // pick the winner: first requester after r_ptr (round-robin) or lowest index
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    if (RoundRobin != 0) begin
      for (int i = 1; i <= NumMasters; i++) begin
        for (int k = 0; k < NumMasters; k++) begin
          if (!w_any && (k == (int'(r_ptr) + i) % NumMasters) && req_i[k]) begin
            w_any = 1'b1;
            w_idx = IdxW'(k);
          end
        end
      end
    end else begin
      for (int k = 0; k < NumMasters; k++) begin
        if (!w_any && req_i[k]) begin
          w_any = 1'b1;
          w_idx = IdxW'(k);
        end
      end
    end
    // nothing is granted while reset is held, whatever the masters drive
    if (!rst_ni) begin
      w_any = 1'b0;
    end
  end

  // route the winner's request fields
  always_comb begin
    w_we    = 1'b0;
    w_be    = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = 0; k < NumMasters; k++) begin
      if (w_idx == IdxW'(k)) begin
        w_we    = we_i[k];
        w_be    = be_i[k*BeWidth +: BeWidth];
        w_addr  = addr_i[k*AddrWidth +: AddrWidth];
        w_wdata = wdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  assign w_inrange = ((w_addr & AddrMask) == AddrBase);
  assign w_access  = w_any && w_inrange;

  // grant vector and RAM port; the port is all-zero unless an in-range access wins
  always_comb begin
    for (int k = 0; k < NumMasters; k++) begin
      gnt_o[k] = w_any && (w_idx == IdxW'(k));
    end
    mem_req_o   = w_access;
    mem_we_o    = w_access ? w_we    : 1'b0;
    mem_be_o    = w_access ? w_be    : '0;
    mem_addr_o  = w_access ? w_addr  : '0;
    mem_wdata_o = w_access ? w_wdata : '0;
  end

  // capture the response for the grant of this cycle and advance the pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= PtrInit;
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rd    <= 1'b0;
    end else begin
      r_rsp_valid <= w_any;
      r_rsp_idx   <= w_idx;
      r_rsp_err   <= w_any && !w_inrange;
      r_rsp_rd    <= w_access && !w_we;
      if (w_any) begin
        r_ptr <= w_idx;
      end
    end
  end

  // response outputs; read data is only forwarded for in-range reads
  always_comb begin
    for (int k = 0; k < NumMasters; k++) begin
      rvalid_o[k] = r_rsp_valid && (r_rsp_idx == IdxW'(k));
      err_o[k]    = r_rsp_valid && (r_rsp_idx == IdxW'(k)) && r_rsp_err;
    end
    rdata_o = (r_rsp_valid && r_rsp_rd) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with three arbiter instances
// (2 masters round-robin with a RAM model, 2 masters fixed priority sharing
// the same stimulus, 4 masters round-robin).
module tb_mem_arbiter;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 2-master stimulus (shared by u_rr2 and u_fp2) ----------------
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [7:0]  be = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;

  logic [1:0]  gnt_a, rvalid_a, err_a;
  logic [31:0] rdata_a, maddr_a, mwdata_a, ram_q;
  logic        mreq_a, mwe_a;
  logic [3:0]  mbe_a;

  logic [1:0]  gnt_b, rvalid_b, err_b;
  logic [31:0] rdata_b, maddr_b, mwdata_b;
  logic        mreq_b, mwe_b;
  logic [3:0]  mbe_b;
  logic [31:0] zero32 = '0;

  // ---------------- 4-master stimulus ----------------
  logic [3:0]   req4 = '0;
  logic [3:0]   we4 = '0;
  logic [15:0]  be4 = '0;
  logic [127:0] addr4 = '0;
  logic [127:0] wdata4 = '0;

  logic [3:0]  gnt_c, rvalid_c, err_c;
  logic [31:0] rdata_c, maddr_c, mwdata_c;
  logic        mreq_c, mwe_c;
  logic [3:0]  mbe_c;

  mem_arbiter #(.NumMasters(2), .RoundRobin(1)) u_rr2 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .err_o(err_a), .rdata_o(rdata_a), .mem_req_o(mreq_a), .mem_we_o(mwe_a),
    .mem_be_o(mbe_a), .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a),
    .mem_rdata_i(ram_q)
  );

  mem_arbiter #(.NumMasters(2), .RoundRobin(0)) u_fp2 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .err_o(err_b), .rdata_o(rdata_b), .mem_req_o(mreq_b), .mem_we_o(mwe_b),
    .mem_be_o(mbe_b), .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b),
    .mem_rdata_i(zero32)
  );

  mem_arbiter #(.NumMasters(4), .RoundRobin(1)) u_rr4 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req4), .we_i(we4), .be_i(be4),
    .addr_i(addr4), .wdata_i(wdata4), .gnt_o(gnt_c), .rvalid_o(rvalid_c),
    .err_o(err_c), .rdata_o(rdata_c), .mem_req_o(mreq_c), .mem_we_o(mwe_c),
    .mem_be_o(mbe_c), .mem_addr_o(maddr_c), .mem_wdata_o(mwdata_c),
    .mem_rdata_i(zero32)
  );

  // ---------------- RAM model for u_rr2: 8 KiB, 1-cycle read latency ----------------
  logic [31:0] ram [0:2047];
  initial begin
    ram_q = '0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'hA500_0000 | i;
  end
  always @(posedge clk) begin
    if (mreq_a) begin
      if (mwe_a) begin
        for (int b = 0; b < 4; b++)
          if (mbe_a[b]) ram[maddr_a[12:2]][b*8 +: 8] <= mwdata_a[b*8 +: 8];
      end else begin
        ram_q <= ram[maddr_a[12:2]];
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset: outputs zero even with requests present
    req = 2'b11;
    addr = {32'h14, 32'h10};
    #1;
    chk("rst_gnt", gnt_a, 2'b00);
    chk("rst_mem_req", mreq_a, 1'b0);
    chk("rst_mem_addr", maddr_a, 32'h0);
    chk("rst_rvalid", rvalid_a, 2'b00);
    chk("rst_rdata", rdata_a, 32'h0);
    req = 2'b00;

    @(negedge clk);
    rst_ni = 1'b1;

    // both masters read continuously for 4 cycles
    @(negedge clk);
    req = 2'b11; we = 2'b00; addr = {32'h14, 32'h10};
    #1;
    chk("rr_c1_gnt", gnt_a, 2'b01);
    chk("rr_c1_rvalid", rvalid_a, 2'b00);
    chk("rr_c1_mem_req", mreq_a, 1'b1);
    chk("rr_c1_mem_addr", maddr_a, 32'h10);
    chk("fp_c1_gnt", gnt_b, 2'b01);

    @(negedge clk); #1;
    chk("rr_c2_gnt", gnt_a, 2'b10);
    chk("rr_c2_mem_addr", maddr_a, 32'h14);
    chk("rr_c2_rvalid", rvalid_a, 2'b01);
    chk("rr_c2_rdata", rdata_a, 32'hA500_0004);
    chk("fp_c2_gnt", gnt_b, 2'b01);
    chk("fp_c2_rvalid", rvalid_b, 2'b01);

    @(negedge clk); #1;
    chk("rr_c3_gnt", gnt_a, 2'b01);
    chk("rr_c3_rvalid", rvalid_a, 2'b10);
    chk("rr_c3_rdata", rdata_a, 32'hA500_0005);
    chk("fp_c3_gnt", gnt_b, 2'b01);

    @(negedge clk); #1;
    chk("rr_c4_gnt", gnt_a, 2'b10);
    chk("rr_c4_rvalid", rvalid_a, 2'b01);
    chk("rr_c4_rdata", rdata_a, 32'hA500_0004);
    chk("fp_c4_gnt", gnt_b, 2'b01);
    chk("fp_c4_rvalid", rvalid_b, 2'b01);

    @(negedge clk);
    req = 2'b00;
    #1;
    chk("idle_gnt", gnt_a, 2'b00);
    chk("idle_rvalid_last", rvalid_a, 2'b10);
    chk("idle_rdata_last", rdata_a, 32'hA500_0005);

    @(negedge clk); #1;
    chk("idle2_rvalid", rvalid_a, 2'b00);
    chk("idle2_rdata", rdata_a, 32'h0);

    // master 1 writes 0xDEADBEEF to 0x100
    req = 2'b10; we = 2'b10; be = 8'hF0;
    addr = {32'h100, 32'h0}; wdata = {32'hDEAD_BEEF, 32'h0};
    #1;
    chk("wr_gnt", gnt_a, 2'b10);
    chk("wr_mem_req", mreq_a, 1'b1);
    chk("wr_mem_we", mwe_a, 1'b1);
    chk("wr_mem_be", mbe_a, 4'hF);
    chk("wr_mem_addr", maddr_a, 32'h100);
    chk("wr_mem_wdata", mwdata_a, 32'hDEAD_BEEF);

    // master 1 reads 0x100 back; write response visible now
    @(negedge clk);
    we = 2'b00; be = 8'h00; wdata = '0;
    #1;
    chk("rd_gnt", gnt_a, 2'b10);
    chk("rd_mem_we", mwe_a, 1'b0);
    chk("wr_rsp_rvalid", rvalid_a, 2'b10);
    chk("wr_rsp_err", err_a, 2'b00);
    chk("wr_rsp_rdata", rdata_a, 32'h0);

    @(negedge clk);
    req = 2'b00;
    #1;
    chk("rd_rsp_rvalid", rvalid_a, 2'b10);
    chk("rd_rsp_err", err_a, 2'b00);
    chk("rd_rsp_rdata", rdata_a, 32'hDEAD_BEEF);
    chk("nogrant_mem_req", mreq_a, 1'b0);
    chk("nogrant_mem_we", mwe_a, 1'b0);
    chk("nogrant_mem_addr", maddr_a, 32'h0);
    chk("nogrant_mem_wdata", mwdata_a, 32'h0);

    // master 0 reads just past the RAM window
    @(negedge clk);
    req = 2'b01; addr = {32'h0, 32'h0000_2000};
    #1;
    chk("oor_gnt", gnt_a, 2'b01);
    chk("oor_mem_req", mreq_a, 1'b0);
    chk("oor_mem_addr", maddr_a, 32'h0);

    @(negedge clk);
    req = 2'b00;
    #1;
    chk("oor_rvalid", rvalid_a, 2'b01);
    chk("oor_err", err_a, 2'b01);
    chk("oor_rdata", rdata_a, 32'h0);

    // grant, then reset before the response is captured
    @(negedge clk);
    req = 2'b01; addr = {32'h24, 32'h20};
    #1;
    chk("pre_rst_gnt", gnt_a, 2'b01);
    #2;
    rst_ni = 1'b0;
    @(negedge clk);
    req = 2'b11;
    #1;
    chk("in_rst_rvalid", rvalid_a, 2'b00);
    chk("in_rst_gnt", gnt_a, 2'b00);
    chk("in_rst_mem_req", mreq_a, 1'b0);

    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_gnt", gnt_a, 2'b01);
    chk("post_rst_rvalid", rvalid_a, 2'b00);

    @(negedge clk); #1;
    chk("post_rst_gnt2", gnt_a, 2'b10);
    chk("post_rst_rvalid2", rvalid_a, 2'b01);
    chk("post_rst_rdata2", rdata_a, 32'hA500_0008);

    @(negedge clk);
    req = 2'b00;

    // 4 masters all requesting for 8 cycles
    @(negedge clk);
    req4 = 4'hF;
    addr4 = {32'h30, 32'h20, 32'h10, 32'h00};
    #1;
    chk("rr4_c0_gnt", gnt_c, 4'b0001);
    chk("rr4_c0_rvalid", rvalid_c, 4'b0000);
    chk("rr4_c0_mem_addr", maddr_c, 32'h00);
    @(negedge clk); #1;
    chk("rr4_c1_gnt", gnt_c, 4'b0010);
    chk("rr4_c1_rvalid", rvalid_c, 4'b0001);
    chk("rr4_c1_mem_addr", maddr_c, 32'h10);
    @(negedge clk); #1;
    chk("rr4_c2_gnt", gnt_c, 4'b0100);
    chk("rr4_c2_rvalid", rvalid_c, 4'b0010);
    chk("rr4_c2_mem_addr", maddr_c, 32'h20);
    @(negedge clk); #1;
    chk("rr4_c3_gnt", gnt_c, 4'b1000);
    chk("rr4_c3_rvalid", rvalid_c, 4'b0100);
    chk("rr4_c3_mem_addr", maddr_c, 32'h30);
    @(negedge clk); #1;
    chk("rr4_c4_gnt", gnt_c, 4'b0001);
    chk("rr4_c4_rvalid", rvalid_c, 4'b1000);
    @(negedge clk); #1;
    chk("rr4_c5_gnt", gnt_c, 4'b0010);
    @(negedge clk); #1;
    chk("rr4_c6_gnt", gnt_c, 4'b0100);
    @(negedge clk); #1;
    chk("rr4_c7_gnt", gnt_c, 4'b1000);
    chk("rr4_c7_rvalid", rvalid_c, 4'b0100);

    @(negedge clk);
    req4 = 4'h0;
    #1;
    chk("rr4_idle_gnt", gnt_c, 4'b0000);
    chk("rr4_idle_rvalid", rvalid_c, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NumMasters, default 2: number of requesting master ports (1..8).
REQ-002 SHALL have parameter AddrWidth, default 32: byte address width.
REQ-003 SHALL have parameter DataWidth, default 32: data width, multiple of 8; BeWidth = DataWidth/8.
REQ-004 SHALL have parameter MemStart, default 32'h00000000: base byte address of the RAM window.
REQ-005 SHALL have parameter MemSize, default 8192: RAM window size in bytes, power of two.
REQ-006 SHALL have parameter RoundRobin, default 1: 1 = round-robin, 0 = fixed priority (master 0 highest).
REQ-007 SHALL use one clock and an asynchronous active-low reset, ports clk_i and rst_ni.
REQ-008 clk_i  in  1  clock; all state on its rising edge.
REQ-009 rst_ni  in  1  asynchronous active-low reset.
REQ-010 req_i  in  NumMasters  per-master request.
REQ-011 we_i  in  NumMasters  per-master write enable.
REQ-012 be_i  in  NumMasters*BeWidth  per-master byte enables, master k in slice k.
REQ-013 addr_i  in  NumMasters*AddrWidth  per-master byte address.
REQ-014 wdata_i  in  NumMasters*DataWidth  per-master write data.
REQ-015 gnt_o  out  NumMasters  per-master grant, one-hot or zero.
REQ-016 rvalid_o  out  NumMasters  per-master response valid.
REQ-017 err_o  out  NumMasters  per-master error, meaningful only with rvalid_o.
REQ-018 rdata_o  out  DataWidth  shared read data, qualified by rvalid_o.
REQ-019 mem_req_o, mem_we_o  out  1 each  RAM request / write enable.
REQ-020 mem_be_o  out  BeWidth; mem_addr_o  out  AddrWidth; mem_wdata_o  out  DataWidth.
REQ-021 mem_rdata_i  in  DataWidth  RAM read data, valid the cycle after mem_req_o (fixed 1-cycle latency).

Function
REQ-022 In range SHALL mean (addr & ~(MemSize-1)) == MemStart.
REQ-023 Arbitration SHALL be combinational: at most one gnt_o bit per cycle, same cycle as the winning req_i.
REQ-024 Fixed priority: lowest-index requesting master wins.
REQ-025 Round-robin: winner is the first requesting index strictly after last-granted pointer, wrapping NumMasters-1 -> 0; pointer updates only on a grant; reset value NumMasters-1 so master 0 wins first.
REQ-026 Granted in-range: mem_req_o=1, mem_we/be/addr/wdata copied from winner's slice in same cycle.
REQ-027 Granted out-of-range: still granted, mem_req_o=0, no RAM access (reads and writes).
REQ-028 No grant: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o all zero.
REQ-029 On grant, response register SHALL capture {valid=1, index, err=out-of-range}; otherwise valid=0.
REQ-030 Cycle after grant: rvalid_o[index]=1, err_o[index]=err; rdata_o=mem_rdata_i for in-range reads, zero for writes and errors.
REQ-031 Writes SHALL also receive exactly one rvalid_o pulse.
REQ-032 rvalid_o, err_o, rdata_o zero when no response pending.
REQ-033 Back-to-back grants every cycle SHALL be supported; response for cycle n and grant for cycle n+1 coexist.
REQ-034 Request fields not latched; masters hold req/addr/we/be/wdata until gnt (unguarded changes undefined).
REQ-035 NumMasters=1: gnt_o=req_i, pointer logic degenerates, no other change.

Reset
REQ-036 While rst_ni=0: gnt_o, rvalid_o, err_o, rdata_o, mem_* outputs all zero, pending response cleared, pointer = NumMasters-1.
REQ-037 Reset asserted with a response pending SHALL drop it; no rvalid_o after release.
REQ-038 First grant possible in first clock edge after rst_ni rises.

Verification
REQ-039 RoundRobin=1, N=2, req_i=2'b11 for 4 cycles -> gnt_o 01,10,01,10; rvalid_o follows one cycle later.
REQ-040 RoundRobin=0, req_i=2'b11 held -> gnt_o=01 every cycle, master 1 starved.
REQ-041 Master 1 write 0xDEADBEEF be=4'hF to 0x100, then read 0x100 -> mem_we_o=1 once; read rvalid_o[1]=1, rdata_o=0xDEADBEEF, err_o=0.
REQ-042 Master 0 read 0x00002000 (MemSize 8192) -> gnt_o[0]=1, mem_req_o=0; next cycle rvalid_o[0]=1, err_o[0]=1, rdata_o=0.
REQ-043 Grant on cycle n, rst_ni low on n+1 -> no rvalid_o; after release req_i=2'b11 -> master 0 granted first.
REQ-044 N=4 RoundRobin=1, all request 8 cycles -> grant order 0,1,2,3,0,1,2,3, exactly one gnt bit per cycle.
